// File: rtl/ad9361_rx_deframer.sv
// AD9361 1R1T RX deframer: aligns to the 1,1,0,0 frame pattern and rebuilds sign-extended 12-bit I/Q samples.
// Latency: out_valid one cycle after the accepted phase-3 word. No backpressure; in_en=0 cycles simply stall.
// Optional saturating error counter built only when AD9361_RX_ERR_CNT_EN is defined.
module ad9361_rx_deframer #(
    parameter int LOCK_FRAMES = 2,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_en,
    input  logic [5:0]           in_data,
    input  logic                 in_frame,
    output logic                 out_valid,
    output logic [15:0]          out_i,
    output logic [15:0]          out_q,
    output logic                 locked,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 err_clr
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  phase_q;
    logic        prev_frame_q;
    logic [5:0]  i_msb_q;
    logic [5:0]  q_msb_q;
    logic [5:0]  i_lsb_q;
    logic [3:0]  good_cnt_q;
    logic        out_valid_q;
    logic [15:0] out_i_q;
    logic [15:0] out_q_q;
    logic        locked_q;
    logic        frame_err_q;

    logic        exp_frame;
    logic        frame_ok;
    logic        lock_err;
    logic [3:0]  good_cnt_inc;
    logic        lock_done;
    logic [11:0] sample_i;
    logic [11:0] sample_q;

    // Phases 0 and 1 carry the MSB halves and are flagged with frame=1.
    assign exp_frame    = ~phase_q[1];
    assign frame_ok     = (in_frame == exp_frame);
    assign lock_err     = in_en && (state_q == ST_LOCKED) && !frame_ok;
    assign good_cnt_inc = good_cnt_q + 4'd1;
    assign lock_done    = (good_cnt_inc == 4'(LOCK_FRAMES));
    assign sample_i     = {i_msb_q, i_lsb_q};
    assign sample_q     = {q_msb_q, in_data};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_SEARCH;
            phase_q      <= 2'd0;
            prev_frame_q <= 1'b1;
            i_msb_q      <= 6'd0;
            q_msb_q      <= 6'd0;
            i_lsb_q      <= 6'd0;
            good_cnt_q   <= 4'd0;
            out_valid_q  <= 1'b0;
            out_i_q      <= 16'd0;
            out_q_q      <= 16'd0;
            locked_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (in_en) begin
                prev_frame_q <= in_frame;
                case (state_q)
                    ST_SEARCH: begin
                        if (in_frame && !prev_frame_q) begin
                            i_msb_q    <= in_data;
                            phase_q    <= 2'd1;
                            good_cnt_q <= 4'd0;
                            state_q    <= ST_ALIGN;
                        end
                    end
                    ST_ALIGN, ST_LOCKED: begin
                        if (!frame_ok) begin
                            // Partial sample is abandoned; prev_frame keeps this word's bit for fast re-acquire.
                            frame_err_q <= 1'b1;
                            locked_q    <= 1'b0;
                            phase_q     <= 2'd0;
                            state_q     <= ST_SEARCH;
                        end else begin
                            phase_q <= phase_q + 2'd1;
                            case (phase_q)
                                2'd0:    i_msb_q <= in_data;
                                2'd1:    q_msb_q <= in_data;
                                2'd2:    i_lsb_q <= in_data;
                                default: begin
                                    if (state_q == ST_LOCKED) begin
                                        out_valid_q <= 1'b1;
                                        out_i_q     <= {{4{sample_i[11]}}, sample_i};
                                        out_q_q     <= {{4{sample_q[11]}}, sample_q};
                                    end else begin
                                        good_cnt_q <= good_cnt_inc;
                                        if (lock_done) begin
                                            locked_q <= 1'b1;
                                            state_q  <= ST_LOCKED;
                                        end
                                    end
                                end
                            endcase
                        end
                    end
                    default: begin
                        phase_q  <= 2'd0;
                        locked_q <= 1'b0;
                        state_q  <= ST_SEARCH;
                    end
                endcase
            end
        end
    end

`ifdef AD9361_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    // Clear takes priority over a coincident increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (lock_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_err;
    assign unused_err = ^{err_clr, lock_err};
    assign err_count  = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign locked    = locked_q;
    assign frame_err = frame_err_q;

endmodule
